in_channel: RTL and testbench
=============================

# in_channel

Input-channel buffer that sits directly upstream of the test-program interpreter. It accepts words from an external producer over a valid/ready handshake and stores them in a circular FIFO. It serves the interpreter's `inSize` instruction (words still unread) and `in` instruction (take next word). It replaces the hard-wired `inMem`/`inMemPos` preload, so programs can be fed at run time.

## Interface

Parameters:
- `MemoryElementWidth`, 12, width of every channel word.
- `NIn`, 8, FIFO depth in words; any value ≥ 1, not required to be a power of two.
- `CountWidth`, `$clog2(NIn+1)`, width of the occupancy count.
- `PosWidth`, 16, width of the consumed-word counter.

Ports:
- `clock` input 1: driving clock; all state changes on its rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `inValid` input 1: producer offers `inData` this cycle.
- `inData` input `MemoryElementWidth`: producer word.
- `inReady` output 1: FIFO will accept a word this cycle.
- `inTake` input 1: interpreter executes `in` and pops the head word this cycle.
- `inWord` output `MemoryElementWidth`: current head word, first-word-fall-through.
- `inSize` output `CountWidth`: words currently held, which is the value the `inSize` instruction returns.
- `inEmpty` output 1: `inSize == 0`.
- `inFull` output 1: `inSize == NIn`.
- `inPos` output `PosWidth`: words popped since reset (interpreter's `inMemPos`).
- `underflow` output 1: sticky; set when `inTake` is asserted while empty.

## Operation

State:
- `mem[NIn]`
- `wrPtr` and `rdPtr`, each in 0..NIn-1
- `count`
- `inPos`
- `underflow`

Reset (synchronous, has priority over everything):
- `wrPtr`, `rdPtr`, `count` and `inPos` are set to 0.
- `underflow` is cleared.
- `mem` contents are not cleared.
- Any push or pop in the reset cycle is ignored.

Push:
- Occurs when `inValid && inReady`.
- Writes `mem[wrPtr] = inData`.
- Advances `wrPtr`, wrapping from NIn-1 to 0.

Pop:
- Occurs when `inTake && !inEmpty`.
- Advances `rdPtr` with the same wrap.
- Increments `inPos`, which saturates at all-ones.

Underflow:
- `inTake && inEmpty` sets `underflow`.
- Pointers, `count` and `inPos` are unchanged. This matches the interpreter rule that `in` on an exhausted channel leaves its target untouched.

Count update:
- `count` increases by 1 on a push alone.
- `count` decreases by 1 on a pop alone.
- `count` is unchanged on a simultaneous push and pop.

Combinational outputs:
- `inReady = !reset && !inFull`. A pop in the same cycle does not free a slot for a push, so there is no full-bypass.
- `inWord = inEmpty ? 0 : mem[rdPtr]`.
- `inSize = count`, `inEmpty = (count == 0)`, `inFull = (count == NIn)`.

Empty-bypass:
- None. A word pushed while empty becomes visible on `inWord` only in the following cycle.
- `inTake` in that same cycle therefore underflows.

`underflow` stays set until reset.

## Timing

- Reset values:
  - `inReady` = 0 during the reset cycle, 1 from the first cycle after it.
  - `inWord` = 0, `inSize` = 0, `inEmpty` = 1, `inFull` = 0, `inPos` = 0, `underflow` = 0.
- Push latency: data accepted at edge N is on `inWord` (if it is the head) and counted in `inSize` after edge N.
- Pop latency: after the popping edge, `inWord` shows the next word and `inSize` reflects the removal.
- Throughput: one push and one pop per cycle sustained whenever 0 < `count` < NIn.
- Handshake:
  - The producer holds `inData` stable while `inValid && !inReady`.
  - The block never drops an accepted word.
- Wrap-around: pointer increments are modulo NIn, which is correct for non-power-of-two NIn.
- Reset mid-operation: in-flight words are discarded; the first post-reset push lands at slot 0.

## Test plan

- Reset, push 88 then 44. Interleave reads of `inSize` with pops → `inSize` 2; pop gives `inWord` 88; `inSize` 1; pop gives 44; `inSize` 0; `inPos` = 2; `underflow` = 0.
- NIn=8: push 8 words 1..8 → `inFull` = 1, `inReady` = 0. A ninth `inValid` with data 9 is held off. Pop once → `inReady` = 1 next cycle; 9 is accepted; pops return 2..9 in order.
- NIn=5: run 13 push/pop pairs with data 100..112 → pointers wrap twice; every popped word matches in order; `inSize` stays 1 throughout the streaming phase.
- Empty, assert `inTake` → `underflow` = 1; `inSize` = 0 and `inPos` = 0 unchanged. Then push 7 and pop → `inWord` = 7 and `underflow` stays 1.
- Empty, assert push (data 33) and `inTake` in the same cycle → push accepted, pop underflows; next cycle `inSize` = 1 and `inWord` = 33.
- Hold 3 words, assert `reset` for one cycle while `inValid` = 1 and `inTake` = 1 → after reset `inSize` = 0, `inEmpty` = 1, `inPos` = 0, `underflow` = 0; the next push of 55 is read back as 55.

Source files
------------

// File: rtl/in_channel_if.sv
// Producer/interpreter side of the input channel.
// The slave side faces the channel buffer.
interface in_channel_if #(
   parameter int MemoryElementWidth = 12,
   parameter int CountWidth = 4,
   parameter int PosWidth = 16
);
   logic inValid;
   logic [MemoryElementWidth-1:0] inData;
   logic inReady;
   logic inTake;
   logic [MemoryElementWidth-1:0] inWord;
   logic [CountWidth-1:0] inSize;
   logic inEmpty;
   logic inFull;
   logic [PosWidth-1:0] inPos;
   logic underflow;

   modport master (
      output inValid, inData, inTake,
      input inReady, inWord, inSize,
      input inEmpty, inFull, inPos, underflow
   );

   modport slave (
      input inValid, inData, inTake,
      output inReady, inWord, inSize,
      output inEmpty, inFull, inPos, underflow
   );
endinterface

// File: rtl/in_channel.sv
// Circular FIFO feeding the interpreter's in/inSize instructions.
// First-word-fall-through head, no empty or full bypass.
module in_channel #(
   parameter int MemoryElementWidth = 12,
   parameter int NIn = 8,
   parameter int CountWidth = $clog2(NIn + 1),
   parameter int PosWidth = 16
) (
   input logic clock,
   input logic reset,
   in_channel_if.slave ch
);
   localparam int PtrWidth = (NIn > 1) ? $clog2(NIn) : 1;
   localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(NIn - 1);

   logic [MemoryElementWidth-1:0] mem [NIn];
   logic [PtrWidth-1:0] wrPtr, rdPtr;
   logic [CountWidth-1:0] count;
   logic [PosWidth-1:0] pos;
   logic uflow;
   logic empty, full;
   logic push, pop;

   assign empty = (count == '0);
   assign full = (count == CountWidth'(NIn));
   assign ch.inReady = !reset && !full;
   assign push = ch.inValid && ch.inReady;
   assign pop = ch.inTake && !empty;

   assign ch.inWord = empty ? '0 : mem[rdPtr];
   assign ch.inSize = count;
   assign ch.inEmpty = empty;
   assign ch.inFull = full;
   assign ch.inPos = pos;
   assign ch.underflow = uflow;

   // Storage is never cleared; inWord is gated while empty.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wrPtr] <= ch.inData;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         pos <= '0;
         uflow <= 1'b0;
      end else begin
         if (push) begin
            wrPtr <= (wrPtr == LastPtr) ? '0 : wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= (rdPtr == LastPtr) ? '0 : rdPtr + 1'b1;
            if (pos != '1) begin
               pos <= pos + 1'b1;
            end
         end
         if (ch.inTake && empty) begin
            uflow <= 1'b1;
         end
         unique case ({push, pop})
            2'b10: count <= count + 1'b1;
            2'b01: count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_in_channel.sv
// Directed bench for in_channel: vector table on an 8-deep
// instance plus hand sequences for full/hold-off and 5-deep wrap.
module tb_in_channel;
   logic clock;
   logic rst8, rst5;
   int tests = 0;
   int fails = 0;

   in_channel_if #(.MemoryElementWidth(12), .CountWidth(4), .PosWidth(16)) ch8 ();
   in_channel_if #(.MemoryElementWidth(12), .CountWidth(3), .PosWidth(16)) ch5 ();

   in_channel #(.MemoryElementWidth(12), .NIn(8), .PosWidth(16)) dut8 (
      .clock(clock), .reset(rst8), .ch(ch8.slave)
   );
   in_channel #(.MemoryElementWidth(12), .NIn(5), .PosWidth(16)) dut5 (
      .clock(clock), .reset(rst5), .ch(ch5.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic r;
      logic v;
      logic [11:0] d;
      logic t;
      logic [11:0] w;
      logic [3:0] s;
      logic e;
      logic f;
      logic rdy;
      logic [15:0] p;
      logic u;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got %0h want %0h", n, a, e);
      end
   endtask

   task automatic add(input logic r, input logic v, input int d, input logic t,
                      input int w, input int s, input logic e, input logic f,
                      input logic rdy, input int p, input logic u);
      vec_t x;
      x.r = r; x.v = v; x.d = 12'(d); x.t = t;
      x.w = 12'(w); x.s = 4'(s); x.e = e; x.f = f;
      x.rdy = rdy; x.p = 16'(p); x.u = u;
      vq.push_back(x);
   endtask

   initial begin
      rst8 = 1'b1;
      rst5 = 1'b1;
      ch8.inValid = 1'b0; ch8.inData = '0; ch8.inTake = 1'b0;
      ch5.inValid = 1'b0; ch5.inData = '0; ch5.inTake = 1'b0;

      //   r  v  d   t  word sz e  f  rdy pos u
      add(1, 0, 0,  0, 0,   0, 1, 0, 0,  0,  0);
      add(0, 1, 88, 0, 0,   0, 1, 0, 1,  0,  0);
      add(0, 1, 44, 0, 88,  1, 0, 0, 1,  0,  0);
      add(0, 0, 0,  0, 88,  2, 0, 0, 1,  0,  0);
      add(0, 0, 0,  1, 88,  2, 0, 0, 1,  0,  0);
      add(0, 0, 0,  0, 44,  1, 0, 0, 1,  1,  0);
      add(0, 0, 0,  1, 44,  1, 0, 0, 1,  1,  0);
      add(0, 0, 0,  0, 0,   0, 1, 0, 1,  2,  0);
      add(0, 0, 0,  1, 0,   0, 1, 0, 1,  2,  0);
      add(0, 1, 7,  0, 0,   0, 1, 0, 1,  2,  1);
      add(0, 0, 0,  1, 7,   1, 0, 0, 1,  2,  1);
      add(0, 0, 0,  0, 0,   0, 1, 0, 1,  3,  1);
      add(1, 0, 0,  0, 0,   0, 1, 0, 0,  3,  1);
      add(0, 1, 33, 1, 0,   0, 1, 0, 1,  0,  0);
      add(0, 0, 0,  0, 33,  1, 0, 0, 1,  0,  1);
      add(0, 1, 1,  0, 33,  1, 0, 0, 1,  0,  1);
      add(0, 1, 2,  0, 33,  2, 0, 0, 1,  0,  1);
      add(1, 1, 99, 1, 33,  3, 0, 0, 0,  0,  1);
      add(0, 0, 0,  0, 0,   0, 1, 0, 1,  0,  0);
      add(0, 1, 55, 0, 0,   0, 1, 0, 1,  0,  0);
      add(0, 0, 0,  0, 55,  1, 0, 0, 1,  0,  0);
      add(0, 0, 0,  1, 55,  1, 0, 0, 1,  0,  0);
      add(0, 0, 0,  0, 0,   0, 1, 0, 1,  1,  0);

      @(posedge clock);
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clock);
         rst8 = vq[i].r;
         ch8.inValid = vq[i].v;
         ch8.inData = vq[i].d;
         ch8.inTake = vq[i].t;
         #1;
         chk($sformatf("v%0d.word", i), 32'(ch8.inWord), 32'(vq[i].w));
         chk($sformatf("v%0d.size", i), 32'(ch8.inSize), 32'(vq[i].s));
         chk($sformatf("v%0d.empty", i), 32'(ch8.inEmpty), 32'(vq[i].e));
         chk($sformatf("v%0d.full", i), 32'(ch8.inFull), 32'(vq[i].f));
         chk($sformatf("v%0d.ready", i), 32'(ch8.inReady), 32'(vq[i].rdy));
         chk($sformatf("v%0d.pos", i), 32'(ch8.inPos), 32'(vq[i].p));
         chk($sformatf("v%0d.uflow", i), 32'(ch8.underflow), 32'(vq[i].u));
      end

      // Fill to full, hold off word 9, then drain.
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         ch8.inValid = 1'b1; ch8.inData = 12'(k); ch8.inTake = 1'b0;
         #1 chk($sformatf("fill%0d.ready", k), 32'(ch8.inReady), 32'd1);
      end
      @(negedge clock);
      ch8.inData = 12'd9;
      #1;
      chk("full.flag", 32'(ch8.inFull), 32'd1);
      chk("full.ready", 32'(ch8.inReady), 32'd0);
      chk("full.size", 32'(ch8.inSize), 32'd8);
      @(negedge clock);
      #1 chk("hold.size", 32'(ch8.inSize), 32'd8);
      @(negedge clock);
      ch8.inTake = 1'b1;
      #1;
      chk("popfull.word", 32'(ch8.inWord), 32'd1);
      chk("popfull.ready", 32'(ch8.inReady), 32'd0);
      @(negedge clock);
      ch8.inTake = 1'b0;
      #1;
      chk("after.ready", 32'(ch8.inReady), 32'd1);
      chk("after.size", 32'(ch8.inSize), 32'd7);
      for (int k = 2; k <= 9; k++) begin
         @(negedge clock);
         ch8.inValid = 1'b0; ch8.inTake = 1'b1;
         #1 chk($sformatf("drain%0d.word", k), 32'(ch8.inWord), 32'(k));
      end
      @(negedge clock);
      ch8.inTake = 1'b0;
      #1;
      chk("drain.empty", 32'(ch8.inEmpty), 32'd1);
      chk("drain.pos", 32'(ch8.inPos), 32'd10);
      chk("drain.uflow", 32'(ch8.underflow), 32'd0);

      // 5-deep streaming: 13 pushes/pops wrap both pointers twice.
      @(negedge clock);
      rst5 = 1'b0;
      ch5.inValid = 1'b1; ch5.inData = 12'd100;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clock);
         ch5.inValid = 1'b1; ch5.inData = 12'(100 + i); ch5.inTake = 1'b1;
         #1;
         chk($sformatf("s5_%0d.word", i), 32'(ch5.inWord), 32'(99 + i));
         chk($sformatf("s5_%0d.size", i), 32'(ch5.inSize), 32'd1);
      end
      @(negedge clock);
      ch5.inValid = 1'b0; ch5.inTake = 1'b1;
      #1 chk("s5_last.word", 32'(ch5.inWord), 32'd112);
      @(negedge clock);
      ch5.inTake = 1'b0;
      #1;
      chk("s5.empty", 32'(ch5.inEmpty), 32'd1);
      chk("s5.pos", 32'(ch5.inPos), 32'd13);
      chk("s5.uflow", 32'(ch5.underflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
